// File: rtl/dm_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: DMType load/store types,
// sequencer states and the access-size helper.
package dm_access_unit_pkg;

  typedef enum logic [2:0] {
    dm_word              = 3'b000,
    dm_halfword          = 3'b001,
    dm_halfword_unsigned = 3'b010,
    dm_byte              = 3'b011,
    dm_byte_unsigned     = 3'b100,
    dm_dword             = 3'b101
  } dm_type_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR1 = 3'd1,
    S_DATA1 = 3'd2,
    S_ADDR2 = 3'd3,
    S_DATA2 = 3'd4,
    S_RESP  = 3'd5
  } dm_state_e;

  // Illegal types report size 1 so the mask math stays well-defined.
  function automatic logic [3:0] dm_size(input logic [2:0] t);
    case (t)
      dm_word:              dm_size = 4'd4;
      dm_halfword:          dm_size = 4'd2;
      dm_halfword_unsigned: dm_size = 4'd2;
      dm_dword:             dm_size = 4'd8;
      default:              dm_size = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Data-SRAM-like bus between the access unit (master) and the memory (slave).
interface dm_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  bus_req;
  logic                  bus_wr;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational lane logic: size/mask, per-beat strobes and shifted store data,
// and load extraction with sign/zero extension over a two-beat window.
module dm_lane_align
  import dm_access_unit_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(BYTES)
) (
  input  logic [2:0]        type_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_lo_i,
  input  logic [DATA_W-1:0] rdata_hi_i,
  output logic              illegal_o,
  output logic              misaligned_o,
  output logic              split_o,
  output logic [BYTES-1:0]  strb1_o,
  output logic [BYTES-1:0]  strb2_o,
  output logic [DATA_W-1:0] wdata1_o,
  output logic [DATA_W-1:0] wdata2_o,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [2*BYTES-1:0] ONE = 1;

  logic [3:0]          size;
  logic [2*BYTES-1:0]  strb_full;
  logic [2*DATA_W-1:0] wdata_full;
  logic [DATA_W-1:0]   rd_shift;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input int bits, input logic sgn);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++)
      r[i] = (i < bits) ? v[i] : (sgn & v[bits-1]);
    return r;
  endfunction

  assign size         = dm_size(type_i);
  assign illegal_o    = (type_i > 3'd5) || ((type_i == dm_dword) && (DATA_W != 64));
  assign misaligned_o = (({{(4-OFF_W){1'b0}}, off_i} & (size - 4'd1)) != 4'd0);
  assign split_o      = ((5'(off_i) + 5'(size)) > 5'(BYTES));

  // Both beats come from one double-width shift: low half is beat 1, high half beat 2.
  assign strb_full  = ((ONE << size) - ONE) << off_i;
  assign wdata_full = {{DATA_W{1'b0}}, wdata_i} << {off_i, 3'b000};
  assign strb1_o    = strb_full[BYTES-1:0];
  assign strb2_o    = strb_full[2*BYTES-1:BYTES];
  assign wdata1_o   = wdata_full[DATA_W-1:0];
  assign wdata2_o   = wdata_full[2*DATA_W-1:DATA_W];

  assign rd_shift = DATA_W'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});

  always_comb begin
    rdata_o = rd_shift;
    case (type_i)
      dm_word:              rdata_o = extend(rd_shift, 32, 1'b1);
      dm_halfword:          rdata_o = extend(rd_shift, 16, 1'b1);
      dm_halfword_unsigned: rdata_o = extend(rd_shift, 16, 1'b0);
      dm_byte:              rdata_o = extend(rd_shift, 8, 1'b1);
      dm_byte_unsigned:     rdata_o = extend(rd_shift, 8, 1'b0);
      default:              rdata_o = rd_shift;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access unit: req/resp handshake plus a bus sequencer. Defining
// DM_MISALIGN_SPLIT_EN splits misaligned accesses into two aligned beats.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_ale,
  dm_access_unit_if.master  bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  dm_state_e         state_q;
  logic              wr_q;
  logic [2:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata1_q;
  logic              resp_valid_q, resp_ale_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              bus_req_q, bus_wr_q;
  logic [BYTES-1:0]  bus_wstrb_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;

  logic              idle;
  logic [2:0]        cur_type;
  logic [ADDR_W-1:0] cur_addr, aligned_addr;
  logic [DATA_W-1:0] cur_wdata, rdata_lo;
  logic              illegal, misaligned, split, reject;
  logic [BYTES-1:0]  strb1, strb2;
  logic [DATA_W-1:0] wdata1, wdata2, ld_rdata;

  // In IDLE the lane logic sees the incoming request so beat 1 can be issued on accept.
  assign idle         = (state_q == S_IDLE);
  assign cur_type     = idle ? req_type  : type_q;
  assign cur_addr     = idle ? req_addr  : addr_q;
  assign cur_wdata    = idle ? req_wdata : wdata_q;
  assign aligned_addr = {cur_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign rdata_lo     = (state_q == S_DATA1) ? bus.bus_rdata : rdata1_q;

  dm_lane_align #(.DATA_W(DATA_W)) u_align (
    .type_i       (cur_type),
    .off_i        (cur_addr[OFF_W-1:0]),
    .wdata_i      (cur_wdata),
    .rdata_lo_i   (rdata_lo),
    .rdata_hi_i   (bus.bus_rdata),
    .illegal_o    (illegal),
    .misaligned_o (misaligned),
    .split_o      (split),
    .strb1_o      (strb1),
    .strb2_o      (strb2),
    .wdata1_o     (wdata1),
    .wdata2_o     (wdata2),
    .rdata_o      (ld_rdata)
  );

`ifdef DM_MISALIGN_SPLIT_EN
  assign reject = illegal;
`else
  logic unused_split;
  assign reject       = illegal | misaligned;
  assign unused_split = split ^ (^strb2) ^ (^wdata2);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      type_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata1_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_ale_q   <= 1'b0;
      resp_rdata_q <= '0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_wstrb_q  <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid) begin
          wr_q    <= req_wr;
          type_q  <= req_type;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          if (reject) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_ale_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            state_q     <= S_ADDR1;
            bus_req_q   <= 1'b1;
            bus_wr_q    <= req_wr;
            bus_addr_q  <= aligned_addr;
            bus_wstrb_q <= req_wr ? strb1 : '0;
            bus_wdata_q <= req_wr ? wdata1 : '0;
          end
        end
        S_ADDR1: if (bus.bus_addr_ok) begin
          bus_req_q <= 1'b0;
          state_q   <= S_DATA1;
        end
        S_DATA1: if (bus.bus_data_ok) begin
          rdata1_q <= bus.bus_rdata;
`ifdef DM_MISALIGN_SPLIT_EN
          if (split) begin
            state_q     <= S_ADDR2;
            bus_req_q   <= 1'b1;
            bus_addr_q  <= aligned_addr + ADDR_W'(BYTES);
            bus_wstrb_q <= wr_q ? strb2 : '0;
            bus_wdata_q <= wr_q ? wdata2 : '0;
          end else
`endif
          begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_ale_q   <= 1'b0;
            resp_rdata_q <= wr_q ? '0 : ld_rdata;
          end
        end
`ifdef DM_MISALIGN_SPLIT_EN
        S_ADDR2: if (bus.bus_addr_ok) begin
          bus_req_q <= 1'b0;
          state_q   <= S_DATA2;
        end
        S_DATA2: if (bus.bus_data_ok) begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_ale_q   <= 1'b0;
          resp_rdata_q <= wr_q ? '0 : ld_rdata;
        end
`endif
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = idle;
  assign resp_valid    = resp_valid_q;
  assign resp_ale      = resp_ale_q;
  assign resp_rdata    = resp_rdata_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_wr    = bus_wr_q;
  assign bus.bus_wstrb = bus_wstrb_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit (DATA_W=32); expectations follow the
// DM_MISALIGN_SPLIT_EN setting of the build.
module tb_dm_access_unit;
  import dm_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ale;
  logic [31:0] resp_rdata;

  dm_access_unit_if #(.DATA_W(32), .ADDR_W(32)) intf ();

  dm_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_ale   (resp_ale),
    .bus        (intf.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] b_addr  [2];
  logic [31:0] b_wdata [2];
  logic [3:0]  b_strb  [2];
  logic        b_wr    [2];
  int          b_cyc   [2];
  int          nbeats;
  int          r_cyc;
  logic [31:0] r_data;
  logic        r_ale;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_word = 32'h3322_1100;
      32'h0000_0104: mem_word = 32'h7766_5544;
      32'h0000_0200: mem_word = 32'h8012_3456;
      32'hFFFF_FFFC: mem_word = 32'h8100_0000;
      32'h0000_0000: mem_word = 32'h0000_00F0;
      default:       mem_word = 32'hA5A5_A5A5;
    endcase
  endfunction

  // One access with addr_ok/data_ok granted immediately; cycles count from accept.
  task automatic access(input logic wr, input logic [2:0] typ,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_type = typ; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    nbeats = 0; r_cyc = -1; r_data = 'x; r_ale = 'x;
    for (int i = 0; i < 2; i++) begin
      b_addr[i] = '0; b_wdata[i] = '0; b_strb[i] = '0; b_wr[i] = 1'b0; b_cyc[i] = -1;
    end
    for (int cyc = 1; cyc <= 12 && r_cyc < 0; cyc++) begin
      @(negedge clk);
      if (intf.bus_req) begin
        if (nbeats < 2) begin
          b_addr[nbeats]  = intf.bus_addr;
          b_wdata[nbeats] = intf.bus_wdata;
          b_strb[nbeats]  = intf.bus_wstrb;
          b_wr[nbeats]    = intf.bus_wr;
          b_cyc[nbeats]   = cyc;
        end
        nbeats++;
        intf.bus_rdata = mem_word(intf.bus_addr);
      end
      if (resp_valid) begin
        r_cyc = cyc; r_data = resp_rdata; r_ale = resp_ale;
      end
    end
    $display("txn wr=%0d type=%0d addr=%h wdata=%h beats=%0d resp_cyc=%0d rdata=%h ale=%0d",
             wr, typ, addr, wdata, nbeats, r_cyc, r_data, r_ale);
  endtask

  task automatic expect_ale(input string tag);
    check({tag, "_beats"}, 64'(nbeats), 64'd0);
    check({tag, "_cyc"},   64'(r_cyc),  64'd1);
    check({tag, "_ale"},   64'(r_ale),  64'd1);
    check({tag, "_rdata"}, 64'(r_data), 64'd0);
  endtask

  task automatic expect_beat(input string tag, input int i, input logic [31:0] addr,
                             input logic [3:0] strb, input logic [31:0] wdata, input logic wr);
    check({tag, "_addr"},  64'(b_addr[i]),  64'(addr));
    check({tag, "_strb"},  64'(b_strb[i]),  64'(strb));
    check({tag, "_wdata"}, 64'(b_wdata[i]), 64'(wdata));
    check({tag, "_wr"},    64'(b_wr[i]),    64'(wr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_type = '0;
    req_addr = '0; req_wdata = '0;
    intf.bus_addr_ok = 1'b1; intf.bus_data_ok = 1'b1; intf.bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  64'(req_ready),      64'd1);
    check("rst_resp_valid", 64'(resp_valid),     64'd0);
    check("rst_resp_ale",   64'(resp_ale),       64'd0);
    check("rst_resp_rdata", 64'(resp_rdata),     64'd0);
    check("rst_bus_req",    64'(intf.bus_req),   64'd0);
    check("rst_bus_wr",     64'(intf.bus_wr),    64'd0);
    check("rst_bus_wstrb",  64'(intf.bus_wstrb), 64'd0);
    check("rst_bus_addr",   64'(intf.bus_addr),  64'd0);
    check("rst_bus_wdata",  64'(intf.bus_wdata), 64'd0);
    rst = 1'b0;

    // Aligned word store
    access(1'b1, dm_word, 32'h100, 32'hDEADBEEF);
    check("sw_beats", 64'(nbeats), 64'd1);
    expect_beat("sw_b1", 0, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b1);
    check("sw_req_cyc",  64'(b_cyc[0]), 64'd1);
    check("sw_resp_cyc", 64'(r_cyc),    64'd3);
    check("sw_rdata",    64'(r_data),   64'd0);
    check("sw_ale",      64'(r_ale),    64'd0);

    // Byte / half loads with sign and zero extension
    access(1'b0, dm_byte, 32'h203, 32'h0);
    check("lb_beats", 64'(nbeats), 64'd1);
    expect_beat("lb_b1", 0, 32'h200, 4'b0000, 32'h0, 1'b0);
    check("lb_rdata", 64'(r_data), 64'hFFFF_FF80);
    check("lb_cyc",   64'(r_cyc),  64'd3);
    access(1'b0, dm_byte_unsigned, 32'h203, 32'h0);
    check("lbu_rdata", 64'(r_data), 64'h0000_0080);
    access(1'b0, dm_halfword, 32'h202, 32'h0);
    check("lh_rdata", 64'(r_data), 64'hFFFF_8012);
    access(1'b0, dm_halfword_unsigned, 32'h202, 32'h0);
    check("lhu_rdata", 64'(r_data), 64'h0000_8012);

    // Aligned half store in the upper lanes
    access(1'b1, dm_halfword, 32'h102, 32'h0000_ABCD);
    check("sh_al_beats", 64'(nbeats), 64'd1);
    expect_beat("sh_al_b1", 0, 32'h100, 4'b1100, 32'hABCD_0000, 1'b1);

    // Misaligned word load
    access(1'b0, dm_word, 32'h102, 32'h0);
`ifdef DM_MISALIGN_SPLIT_EN
    check("lw_mis_beats", 64'(nbeats), 64'd2);
    expect_beat("lw_mis_b1", 0, 32'h100, 4'b0000, 32'h0, 1'b0);
    expect_beat("lw_mis_b2", 1, 32'h104, 4'b0000, 32'h0, 1'b0);
    check("lw_mis_b2_cyc", 64'(b_cyc[1]), 64'd3);
    check("lw_mis_cyc",    64'(r_cyc),    64'd5);
    check("lw_mis_rdata",  64'(r_data),   64'h5544_3322);
    check("lw_mis_ale",    64'(r_ale),    64'd0);
`else
    expect_ale("lw_mis");
`endif

    // Misaligned half store crossing the word boundary
    access(1'b1, dm_halfword, 32'h103, 32'h0000_ABCD);
`ifdef DM_MISALIGN_SPLIT_EN
    check("sh_mis_beats", 64'(nbeats), 64'd2);
    expect_beat("sh_mis_b1", 0, 32'h100, 4'b1000, 32'hCD00_0000, 1'b1);
    expect_beat("sh_mis_b2", 1, 32'h104, 4'b0001, 32'h0000_00AB, 1'b1);
    check("sh_mis_ale", 64'(r_ale), 64'd0);
`else
    expect_ale("sh_mis");
`endif

    // Split at the top of the address space wraps beat 2 to zero
    access(1'b0, dm_halfword, 32'hFFFF_FFFF, 32'h0);
`ifdef DM_MISALIGN_SPLIT_EN
    check("lh_wrap_beats", 64'(nbeats), 64'd2);
    check("lh_wrap_b1",    64'(b_addr[0]), 64'hFFFF_FFFC);
    check("lh_wrap_b2",    64'(b_addr[1]), 64'h0);
    check("lh_wrap_rdata", 64'(r_data),    64'hFFFF_F081);
`else
    expect_ale("lh_wrap");
`endif

    // Illegal types
    access(1'b0, 3'b110, 32'h100, 32'h0);
    expect_ale("type6");
    access(1'b1, dm_dword, 32'h100, 32'h1234);
    expect_ale("dword32");

    // Reset while waiting for data, then a late data_ok
    @(negedge clk);
    intf.bus_data_ok = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_type = dm_word; req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    intf.bus_data_ok = 1'b1;
    @(negedge clk);
    check("post_rst_ready",   64'(req_ready),     64'd1);
    check("post_rst_bus_req", 64'(intf.bus_req),  64'd0);
    check("post_rst_resp",    64'(resp_valid),    64'd0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || intf.bus_req) seen++;
    end
    check("post_rst_quiet", 64'(seen), 64'd0);
    $display("txn reset-in-DATA1 quiet_cycles_with_activity=%0d", seen);

    access(1'b0, dm_word, 32'h100, 32'h0);
    check("lw_after_rst_rdata", 64'(r_data), 64'h3322_1100);
    check("lw_after_rst_cyc",   64'(r_cyc),  64'd3);
    check("lw_after_rst_ale",   64'(r_ale),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
Parametrised data-memory access unit between the MEM pipeline stage and a data-SRAM-like bus. Generates byte strobes and lane-shifted write data for stores, and extracts and sign- or zero-extends load data. It generalises the fixed 32-bit, single-beat store-enable and load-extend logic to a DATA_W-wide bus, adds a req/ready handshake, and runs a sequencer that can split misaligned accesses into two aligned bus beats.

Parameters:
DATA_W, 32, bus and register data width; 32 or 64.
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  MEM stage presents an access.
req_ready  out  1  unit can accept; high only in IDLE.
req_wr  in  1  1 = store, 0 = load.
req_type  in  3  DMType: 0 word, 1 half, 2 half-unsigned, 3 byte, 4 byte-unsigned, 5 dword (DATA_W=64 only).
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, LSB-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  DATA_W  extended load data; 0 for stores.
resp_ale  out  1  address/type error flag, valid with resp_valid.
bus_req  out  1  bus address-phase request.
bus_wr  out  1  bus write.
bus_wstrb  out  DATA_W/8  byte strobes; all-zero on reads.
bus_addr  out  ADDR_W  address, always DATA_W/8-aligned.
bus_wdata  out  DATA_W  lane-shifted write data.
bus_addr_ok  in  1  address phase accepted.
bus_data_ok  in  1  data phase complete; bus_rdata valid.
bus_rdata  in  DATA_W  aligned read data.

Behaviour:
- BYTES = DATA_W/8. off = addr[log2(BYTES)-1:0]. size is 4/2/2/1/1/8 by type. mask = (1<<size)-1.
- States: IDLE, ADDR1, DATA1, ADDR2, DATA2, RESP.
- Reset: state IDLE. req_ready=1. resp_valid, resp_ale, resp_rdata, bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata all 0.
- IDLE: on req_valid&&req_ready, latch the request.
  - Go to RESP with ale=1 if the type is illegal (6, 7, or 5 when DATA_W=32).
  - Go to RESP with ale=1 if the access is misaligned (off % size != 0) and the split feature is absent.
  - Otherwise go to ADDR1.
- ADDR1/ADDR2: bus_req=1 and bus signals stable until bus_addr_ok; then go to DATA1/DATA2. bus_data_ok is ignored in ADDR states (bus contract: data_ok no earlier than the cycle after addr_ok).
- DATA1: on bus_data_ok, capture rdata1. Go to ADDR2 if split (off+size > BYTES), else RESP.
- DATA2: on bus_data_ok, capture rdata2 and go to RESP.
- Beat 1:
  - addr = aligned addr.
  - wstrb = (mask<<off) truncated to BYTES bits.
  - wdata = wdata<<(8*off).
- Beat 2:
  - addr = aligned addr + BYTES (wraps modulo 2^ADDR_W).
  - wstrb = mask>>(BYTES-off).
  - wdata = wdata>>(8*(BYTES-off)).
- Load result: ({rdata2,rdata1} >> 8*off), low DATA_W bits, then extension.
  - Sign-extend for types 1 and 3; zero-extend for types 2 and 4.
  - Word on DATA_W=64: sign-extend from bit 31.
- RESP: resp_valid=1 for exactly one cycle with registered rdata/ale, then IDLE. No back-pressure on the response.
- Latency, aligned access with addr_ok and data_ok each granted immediately: accept at T, bus_req at T+1, data_ok at T+2, resp_valid at T+3. ALE response: resp_valid at T+1.
- In IDLE and RESP, bus_req=0 and stray bus_data_ok is ignored.
- rst in any state: next cycle IDLE with reset values. A data_ok still outstanding from an in-flight beat is dropped, and no response is produced.

Optional Feature:
DM_MISALIGN_SPLIT_EN:
- Defined: misaligned legal accesses take two aligned beats as described above. resp_ale is set only for illegal types.
- Undefined: ADDR2/DATA2 are unreachable and removed. Misaligned accesses get resp_ale=1 one cycle after accept, with no bus activity.

Decomposition:
- Shared package/include (beside ctrl_encode_def.v): DMType encodings, including new dm_dword=3'b101, and the state encodings.
- Sub-module dm_lane_align: purely combinational. Computes size, mask, beat strobes, shifted wdata, and load extraction/extension. Instantiated once.
- The FSM stays in dm_access_unit.

Test Plan:
1. sw addr 0x100, wdata 0xDEADBEEF -> one beat: bus_addr 0x100, wstrb 4'b1111, wdata 0xDEADBEEF; resp_valid at T+3 with immediate oks.
2. lb addr 0x203, bus_rdata 0x80123456 -> resp_rdata 0xFFFFFF80. Same access as lbu -> 0x00000080.
3. With macro, lw addr 0x102:
   - Beat 1: addr 0x100, rdata 0x33221100.
   - Beat 2: addr 0x104, rdata 0x77665544.
   - Expect resp_rdata 0x55443322, ale 0.
4. Without macro, lw addr 0x102 -> no bus_req; resp_valid and resp_ale=1 at T+1. Type 3'b110 in either build -> same response.
5. With macro, sh addr 0x103, wdata 0xABCD:
   - Beat 1: addr 0x100, wstrb 4'b1000, wdata 0xCD000000.
   - Beat 2: addr 0x104, wstrb 4'b0001, wdata 0x000000AB.
6. rst pulsed in DATA1, then a late bus_data_ok -> IDLE, req_ready=1, bus_req=0; no resp_valid. A following aligned lw completes normally.
